// File: rtl/sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
// Latency: none. This file holds declarations only.
// Backpressure: not applicable.
package sub_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/borrow_la_gen.sv
// 4-bit borrow-lookahead slice that computes d = a - b - bin and the slice borrow-out.
// Latency: purely combinational, so the result is available in the same cycle.
// Backpressure: none. Timing is set by the caller.
// Ports: a, b (4-bit operands), bin (borrow-in) -> d (4-bit difference), bout (borrow-out)
module borrow_la_gen
    import sub_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);

    logic [SLICE_W-1:0] g;   // this bit generates a borrow
    logic [SLICE_W-1:0] p;   // this bit propagates an incoming borrow
    logic [SLICE_W:0]   br;  // borrow into each bit; br[4] is the slice borrow-out

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Each borrow is written out as a sum of products, so no borrow waits on a lower one.
    assign br[0] = bin;
    assign br[1] = g[0] | (p[0] & bin);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d    = a ^ b ^ br[SLICE_W-1:0];
    assign bout = br[SLICE_W];

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle subtractor that computes diff = a - b - bin one 4-bit slice per clock, starting with the LSB slice.
// Latency: out_valid rises NIBBLES edges after the accept edge. Throughput is one result per NIBBLES+2 cycles.
// Backpressure: in_ready is high only in IDLE. The result is held in DONE until out_ready is seen.
// Ports: clk, rst (async, active-high), in_valid/in_ready, a, b, bin,
//        out_valid/out_ready, diff, bout (unsigned borrow-out), ovf (signed overflow)
module nibble_serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 16   // WIDTH must be a multiple of 4 and at least 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / SLICE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_d;
    logic               slice_bout;

    // A single slice generator is shared by every nibble. The counter picks the nibble used this cycle.
    assign slice_a = a_q[int'(cnt_q) * SLICE_W +: SLICE_W];
    assign slice_b = b_q[int'(cnt_q) * SLICE_W +: SLICE_W];

    borrow_la_gen u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        borrow_d    = borrow_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    borrow_d   = bin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                diff_d[int'(cnt_q) * SLICE_W +: SLICE_W] = slice_d;
                borrow_d = slice_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Signed overflow occurs when the operand signs differ and the result sign differs from a.
                    // slice_d[3] is the final MSB of the difference.
                    cnt_d       = '0;
                    bout_d      = slice_bout;
                    ovf_d       = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                                & (a_q[WIDTH-1] ^ slice_d[SLICE_W-1]);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            borrow_q    <= borrow_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed and random bench for nibble_serial_sub with WIDTH=16, using a scoreboard of expected results.
// Latency: each issued operation expects out_valid exactly 4 edges after the accept edge.
// Backpressure: holds out_ready low while in DONE and applies an asynchronous reset in the middle of an operation.
module tb_nibble_serial_sub;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int   vectors = 0;
    int   miscompares = 0;
    res_t exp_q[$];

    nibble_serial_sub #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        logic [16:0] t;
        res_t r;
        t      = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        r.diff = t[15:0];
        r.bout = t[16];
        r.ovf  = (ma[15] ^ mb[15]) & (ma[15] ^ t[15]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for in_ready, presents one operation for a single cycle, and records its expected result.
    task automatic issue(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_, tbin));
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Change the inputs after accept. The DUT must keep the operands it latched.
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int n = 1;
        @(posedge clk); #1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
    endtask

    task automatic take(input string tag);
        res_t e;
        out_ready = 1'b1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
            chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
            chk({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        res_t held;

        // Check the values the DUT shows while held in reset.
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      32'(diff),      32'd0);
        chk("rst_bout",      32'(bout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed operations.
        issue("t1", 16'h1234, 16'h0234, 1'b0); wait_valid("t1"); take("t1");
        issue("t2", 16'h0000, 16'h0001, 1'b0); wait_valid("t2"); take("t2");
        issue("t3", 16'h8000, 16'h0001, 1'b0); wait_valid("t3"); take("t3");
        issue("t4", 16'h00F0, 16'h000F, 1'b1); wait_valid("t4"); take("t4");
        issue("t4b", 16'h5555, 16'h5555, 1'b1); wait_valid("t4b"); take("t4b");
        issue("t4c", 16'h7FFF, 16'hFFFF, 1'b0); wait_valid("t4c"); take("t4c");

        // Stall in DONE while new operands are offered on the input.
        issue("t5", 16'hC3A5, 16'h5A3C, 1'b1); wait_valid("t5");
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            chk("t5_hold_out_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_diff",      32'(diff),      32'(held.diff));
            chk("t5_hold_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        take("t5");

        // Assert reset during the second RUN cycle.
        issue("t6_abort", 16'hABCD, 16'h0001, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_in_ready",  32'(in_ready),  32'd1);
        chk("t6_rst_diff",      32'(diff),      32'd0);
        chk("t6_rst_bout",      32'(bout),      32'd0);
        chk("t6_rst_ovf",       32'(ovf),       32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_release_in_ready", 32'(in_ready), 32'd1);
        issue("t6", 16'h0005, 16'h0003, 1'b0); wait_valid("t6"); take("t6");

        // Random operations.
        for (int i = 0; i < 8; i++) begin
            issue("rnd", 16'($urandom), 16'($urandom), 1'($urandom));
            wait_valid("rnd");
            take("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
